// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, constants and helpers
//
// Purpose: common definitions for BCD arithmetic blocks.
//   BCD_DIGIT_W      width of one packed BCD digit
//   BCD_MAX_DIGIT    largest legal BCD digit value
//   bcd2bin_state_t  state encoding of the BCD-to-binary sequencer
//   bcd_digit_ok()   1 when a nibble is a legal BCD digit (0..9)
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } bcd2bin_state_t;

   function automatic logic bcd_digit_ok(input logic [BCD_DIGIT_W-1:0] nibble);
      return (nibble <= BCD_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// rtl/bcd_mac10.sv - combinational acc*10 + digit step with saturation
//
// Purpose: one multiply-by-ten-and-add step of a BCD-to-binary conversion.
// Ports:
//   acc_in   running accumulator (OUT_W+4 bits, upper bits zero when clamped)
//   digit    next BCD digit; values above 9 are treated as 9
//   acc_out  next accumulator, clamped to 2^OUT_W-1
//   sat      the unclamped result exceeded 2^OUT_W-1
//   bad      digit was not a legal BCD digit
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic [OUT_W+3:0]       acc_in,
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [OUT_W+3:0]       acc_out,
   output logic                   sat,
   output logic                   bad
);

   localparam logic [OUT_W+3:0] ACC_MAX = {4'b0000, {OUT_W{1'b1}}};

   logic [BCD_DIGIT_W-1:0] digit_eff;
   logic [OUT_W+3:0]       sum;

   always_comb begin
      bad       = !bcd_digit_ok(digit);
      digit_eff = bad ? BCD_MAX_DIGIT : digit;
      // acc_in never exceeds ACC_MAX, so the sum always fits in OUT_W+4 bits.
      sum       = (acc_in << 3) + (acc_in << 1) + {{OUT_W{1'b0}}, digit_eff};
      sat       = (sum > ACC_MAX);
      acc_out   = sat ? ACC_MAX : sum;
   end

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential packed-BCD to binary converter
//
// Purpose: converts NDIGITS packed BCD digits to binary, one digit per clock,
// most-significant digit first, with a start/busy/done handshake.
// Optional build macro: BCD2BIN_LZ_SKIP_EN skips leading zero digits.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      conversion request, sampled only in IDLE
//   bcd_in     packed BCD operand, digit NDIGITS-1 in the MSBs
//   busy       conversion in flight (CONV or DONE)
//   done       one-cycle pulse when bin_out/ovf/bad_digit are updated
//   bin_out    binary result, saturated to all ones on overflow
//   ovf        result exceeded 2^OUT_W-1
//   bad_digit  an input nibble was greater than 9
module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter int NDIGITS = 5,
   parameter int OUT_W   = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [BCD_DIGIT_W*NDIGITS-1:0] bcd_in,
   output logic                           busy,
   output logic                           done,
   output logic [OUT_W-1:0]               bin_out,
   output logic                           ovf,
   output logic                           bad_digit
);

   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int BCD_W = BCD_DIGIT_W * NDIGITS;

   bcd2bin_state_t state_q, state_d;
   logic [BCD_W-1:0]       bcd_q, bcd_d;
   logic [OUT_W+3:0]       acc_q, acc_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   ovf_flag_q, ovf_flag_d;
   logic                   bad_flag_q, bad_flag_d;
   logic [OUT_W-1:0]       bin_out_q, bin_out_d;
   logic                   ovf_q, ovf_d;
   logic                   bad_digit_q, bad_digit_d;
   logic                   done_q, done_d;

   logic [BCD_DIGIT_W-1:0] cur_digit;
   logic [OUT_W+3:0]       mac_acc;
   logic                   mac_sat;
   logic                   mac_bad;
   logic [IDX_W-1:0]       idx_start;

   // Digit currently being consumed, selected from the latched operand.
   always_comb begin
      cur_digit = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_digit = bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W];
         end
      end
   end

   bcd_mac10 #(
      .OUT_W (OUT_W)
   ) u_mac10 (
      .acc_in  (acc_q),
      .digit   (cur_digit),
      .acc_out (mac_acc),
      .sat     (mac_sat),
      .bad     (mac_bad)
   );

`ifdef BCD2BIN_LZ_SKIP_EN
   // Leading zero digits contribute nothing to acc*10+d starting from 0, so
   // the first digit processed can be the first non-zero one. At least one
   // step always runs so an all-zero operand still takes the CONV path.
   int   lz_cnt;
   logic lz_found;

   always_comb begin
      lz_cnt   = 0;
      lz_found = 1'b0;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         if (!lz_found && (bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0)) begin
            lz_cnt = lz_cnt + 1;
         end else begin
            lz_found = 1'b1;
         end
      end
      if (lz_cnt >= NDIGITS) begin
         idx_start = '0;
      end else begin
         idx_start = IDX_W'(NDIGITS - 1 - lz_cnt);
      end
   end
`else
   assign idx_start = IDX_W'(NDIGITS - 1);
`endif

   always_comb begin
      state_d     = state_q;
      bcd_d       = bcd_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      ovf_flag_d  = ovf_flag_q;
      bad_flag_d  = bad_flag_q;
      bin_out_d   = bin_out_q;
      ovf_d       = ovf_q;
      bad_digit_d = bad_digit_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               bcd_d      = bcd_in;
               acc_d      = '0;
               idx_d      = idx_start;
               ovf_flag_d = 1'b0;
               bad_flag_d = 1'b0;
               state_d    = CONV;
            end
         end
         CONV: begin
            acc_d      = mac_acc;
            ovf_flag_d = ovf_flag_q | mac_sat;
            bad_flag_d = bad_flag_q | mac_bad;
            if (idx_q == '0) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         DONE: begin
            // Results are published on the edge leaving DONE, together with
            // the done pulse, so done and the new outputs appear together.
            bin_out_d   = acc_q[OUT_W-1:0];
            ovf_d       = ovf_flag_q;
            bad_digit_d = bad_flag_q;
            done_d      = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bcd_q       <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         ovf_flag_q  <= 1'b0;
         bad_flag_q  <= 1'b0;
         bin_out_q   <= '0;
         ovf_q       <= 1'b0;
         bad_digit_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcd_q       <= bcd_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         ovf_flag_q  <= ovf_flag_d;
         bad_flag_q  <= bad_flag_d;
         bin_out_q   <= bin_out_d;
         ovf_q       <= ovf_d;
         bad_digit_q <= bad_digit_d;
         done_q      <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign bin_out   = bin_out_q;
   assign ovf       = ovf_q;
   assign bad_digit = bad_digit_q;

endmodule
